// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
//   Carries the ID-stage control word through the ID/EX, EX/MEM and MEM/WB
//   pipeline registers. Also generates the hazard controls for a 5-stage
//   pipeline: load-use stalls, branch/jump flushes, EX-stage forwarding
//   selects and PCSrcE.
//
// Ports
//   clk, reset               : clock, synchronous active-high reset
//   *D inputs                : decoded ID-stage controls and register addresses
//   ZeroE                    : ALU zero flag from the EX stage
//   ALUSrcE, ALUControlE     : EX-stage controls (registered)
//   Rs1E, Rs2E               : EX-stage source addresses (registered)
//   MemWriteM, MemReadM      : MEM-stage controls (registered)
//   RegWriteW, ResultSrcW    : WB-stage controls (registered)
//   RdW                      : WB-stage destination (registered)
//   PCSrcE                   : take branch/jump target (combinational)
//   StallF, StallD           : hold the PC and IF/ID (combinational)
//   FlushD, FlushE           : clear IF/ID and ID/EX (combinational)
//   ForwardAE, ForwardBE     : 00 regfile, 10 ALUResultM, 01 ResultW
//   stall_cnt, flush_cnt     : saturating event counters
//
// Handshake note: there is no valid/ready interface here. A stalled D word
// must be re-presented by the upstream stage on the next cycle. The ID/EX
// register is never stalled; a bubble enters it instead.
module pipe_ctrl_hazard #(
  parameter int REG_W  = 5,
  parameter int ALUC_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              MemWriteD,
  input  logic              MemReadD,
  input  logic              ALUSrcD,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  RdD,
  input  logic              ZeroE,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              MemWriteM,
  output logic              MemReadM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_W-1:0]  RdW,
  output logic [REG_W-1:0]  Rs1E,
  output logic [REG_W-1:0]  Rs2E,
  output logic              PCSrcE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // E-stage fields that are not brought out as ports
  logic              BranchE, JumpE, MemWriteE, MemReadE, RegWriteE;
  logic [1:0]        ResultSrcE;
  logic [REG_W-1:0]  RdE;
  // M-stage fields that are not brought out as ports
  logic              RegWriteM;
  logic [1:0]        ResultSrcM;
  logic [REG_W-1:0]  RdM;

  logic lw_stall;

  // Hazard logic, combinational from the current state and the D inputs
  always_comb begin
    PCSrcE    = JumpE | (BranchE & ZeroE);
    // A redirect means the D instruction is on the wrong path, so there is
    // no reason to stall it.
    lw_stall  = MemReadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;
    StallF    = lw_stall;
    StallD    = lw_stall;
    FlushD    = PCSrcE;
    FlushE    = lw_stall | PCSrcE;

    // MEM has priority over WB: it holds the younger result.
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  // ID/EX register: flush loads an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      MemWriteE   <= 1'b0;
      MemReadE    <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
    end else begin
      BranchE     <= BranchD;
      JumpE       <= JumpD;
      MemWriteE   <= MemWriteD;
      MemReadE    <= MemReadD;
      ALUSrcE     <= ALUSrcD;
      RegWriteE   <= RegWriteD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  // EX/MEM and MEM/WB registers: these advance every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      MemWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      RegWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
      RdW        <= '0;
    end else begin
      MemWriteM  <= MemWriteE;
      MemReadM   <= MemReadE;
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (PCSrcE && (flush_cnt != '1))   flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Bench for pipe_ctrl_hazard. The main DUT uses the default counter width.
// A second DUT with a 2-bit counter width shares the same inputs so that
// counter saturation can be observed.
module tb_pipe_ctrl_hazard;

  localparam int REG_W  = 5;
  localparam int ALUC_W = 3;

  typedef struct packed {
    logic              branch;
    logic              jump;
    logic              memwrite;
    logic              memread;
    logic              alusrc;
    logic              regwrite;
    logic [1:0]        resultsrc;
    logic [ALUC_W-1:0] aluc;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
  } ctrl_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              BranchD = 0, JumpD = 0, MemWriteD = 0, MemReadD = 0, ALUSrcD = 0, RegWriteD = 0;
  logic [1:0]        ResultSrcD = 0;
  logic [ALUC_W-1:0] ALUControlD = 0;
  logic [REG_W-1:0]  Rs1D = 0, Rs2D = 0, RdD = 0;
  logic              ZeroE = 0;
  logic              ALUSrcE, MemWriteM, MemReadM, RegWriteW, PCSrcE;
  logic              StallF, StallD, FlushD, FlushE;
  logic [ALUC_W-1:0] ALUControlE;
  logic [1:0]        ResultSrcW, ForwardAE, ForwardBE;
  logic [REG_W-1:0]  RdW, Rs1E, Rs2E;
  logic [15:0]       stall_cnt, flush_cnt;

  logic              s_ALUSrcE, s_MemWriteM, s_MemReadM, s_RegWriteW, s_PCSrcE;
  logic              s_StallF, s_StallD, s_FlushD, s_FlushE;
  logic [ALUC_W-1:0] s_ALUControlE;
  logic [1:0]        s_ResultSrcW, s_ForwardAE, s_ForwardBE;
  logic [REG_W-1:0]  s_RdW, s_Rs1E, s_Rs2E;
  logic [1:0]        s_stall_cnt, s_flush_cnt;

  pipe_ctrl_hazard #(.REG_W(REG_W), .ALUC_W(ALUC_W), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .BranchD(BranchD), .JumpD(JumpD), .MemWriteD(MemWriteD), .MemReadD(MemReadD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl_hazard #(.REG_W(REG_W), .ALUC_W(ALUC_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset),
    .BranchD(BranchD), .JumpD(JumpD), .MemWriteD(MemWriteD), .MemReadD(MemReadD),
    .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUSrcE(s_ALUSrcE), .ALUControlE(s_ALUControlE), .MemWriteM(s_MemWriteM), .MemReadM(s_MemReadM),
    .RegWriteW(s_RegWriteW), .ResultSrcW(s_ResultSrcW), .RdW(s_RdW), .Rs1E(s_Rs1E), .Rs2E(s_Rs2E),
    .PCSrcE(s_PCSrcE), .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- reference model ----------------
  // pipe[0] is the word in EX, pipe[1] in MEM, pipe[2] in WB.
  ctrl_t pipe[$];
  int    n_stall_ev = 0;
  int    n_flush_ev = 0;
  bit    model_valid = 0;

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs, input ctrl_t m, input ctrl_t w);
    if (m.regwrite && m.rd != 0 && m.rd == rs) return 2'b10;
    if (w.regwrite && w.rd != 0 && w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- driver: one cycle ----------------
  task automatic step(input ctrl_t d, input logic z, input logic rst);
    ctrl_t e, m, w, zero_w;
    logic  exp_pc, exp_lw;
    zero_w = '0;
    @(negedge clk);
    reset = rst;
    BranchD = d.branch; JumpD = d.jump; MemWriteD = d.memwrite; MemReadD = d.memread;
    ALUSrcD = d.alusrc; RegWriteD = d.regwrite; ResultSrcD = d.resultsrc;
    ALUControlD = d.aluc; Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd; ZeroE = z;
    #1;
    e = pipe[0]; m = pipe[1]; w = pipe[2];
    exp_pc = e.jump | (e.branch & z);
    exp_lw = e.memread && (e.rd != 0) && (e.rd == d.rs1 || e.rd == d.rs2) && !exp_pc;
    if (model_valid) begin
      chk("ALUSrcE",     ALUSrcE,     e.alusrc);
      chk("ALUControlE", ALUControlE, e.aluc);
      chk("Rs1E",        Rs1E,        e.rs1);
      chk("Rs2E",        Rs2E,        e.rs2);
      chk("MemWriteM",   MemWriteM,   m.memwrite);
      chk("MemReadM",    MemReadM,    m.memread);
      chk("RegWriteW",   RegWriteW,   w.regwrite);
      chk("ResultSrcW",  ResultSrcW,  w.resultsrc);
      chk("RdW",         RdW,         w.rd);
      chk("PCSrcE",      PCSrcE,      exp_pc);
      chk("StallF",      StallF,      exp_lw);
      chk("StallD",      StallD,      exp_lw);
      chk("FlushD",      FlushD,      exp_pc);
      chk("FlushE",      FlushE,      exp_lw | exp_pc);
      chk("ForwardAE",   ForwardAE,   fwd_sel(e.rs1, m, w));
      chk("ForwardBE",   ForwardBE,   fwd_sel(e.rs2, m, w));
      chk("stall_cnt",   stall_cnt,   sat(n_stall_ev, 65535));
      chk("flush_cnt",   flush_cnt,   sat(n_flush_ev, 65535));
      chk("stall_cnt_sat", s_stall_cnt, sat(n_stall_ev, 3));
      chk("flush_cnt_sat", s_flush_cnt, sat(n_flush_ev, 3));
      chk("sat_ForwardAE", s_ForwardAE, fwd_sel(e.rs1, m, w));
    end
    @(posedge clk);
    if (rst) begin
      pipe = '{zero_w, zero_w, zero_w};
      n_stall_ev = 0;
      n_flush_ev = 0;
      model_valid = 1;
    end else begin
      if (exp_lw) n_stall_ev++;
      if (exp_pc) n_flush_ev++;
      pipe.push_front((exp_lw || exp_pc) ? zero_w : d);
      void'(pipe.pop_back());
    end
  endtask

  function automatic ctrl_t mk(input logic br, input logic jp, input logic mr, input logic rw,
                               input logic [2:0] alu, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.branch = br; c.jump = jp; c.memread = mr; c.regwrite = rw;
    c.resultsrc = mr ? 2'b01 : 2'b00;
    c.alusrc = mr; c.aluc = alu; c.rs1 = rs1; c.rs2 = rs2; c.rd = rd;
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    ctrl_t nop, busy, r;
    nop  = '0;
    busy = '1;
    pipe = '{nop, nop, nop};

    // reset held two cycles with nonzero D inputs
    step(busy, 1'b1, 1'b1);
    step(busy, 1'b1, 1'b1);
    // first valid word after reset
    step(mk(0, 0, 0, 1, 3'd5, 5'd1, 5'd2, 5'd9), 0, 0);
    step(nop, 0, 0);

    // load-use: lw x5 followed by a reader of x5 (re-presented after the stall)
    step(mk(0, 0, 1, 1, 3'd0, 5'd1, 5'd0, 5'd5), 0, 0);
    step(mk(0, 0, 0, 1, 3'd2, 5'd5, 5'd6, 5'd8), 0, 0);
    step(mk(0, 0, 0, 1, 3'd2, 5'd5, 5'd6, 5'd8), 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);

    // MEM forwarding and MEM-over-WB priority
    step(mk(0, 0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd3), 0, 0);
    step(mk(0, 0, 0, 1, 3'd0, 5'd1, 5'd2, 5'd3), 0, 0);
    step(mk(0, 0, 0, 1, 3'd1, 5'd3, 5'd3, 5'd4), 0, 0);
    step(nop, 0, 0);
    step(nop, 0, 0);

    // branch taken (Zero=1 while it sits in EX), then branch not taken
    step(mk(1, 0, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0), 0, 0);
    step(mk(0, 0, 0, 1, 3'd0, 5'd1, 5'd1, 5'd2), 1, 0);
    step(mk(1, 0, 0, 0, 3'd1, 5'd1, 5'd2, 5'd0), 0, 0);
    step(mk(0, 0, 0, 1, 3'd0, 5'd1, 5'd1, 5'd2), 0, 0);
    step(nop, 0, 0);

    // load that also redirects: the stall must be suppressed
    step(mk(0, 1, 1, 1, 3'd0, 5'd0, 5'd0, 5'd7), 0, 0);
    step(mk(0, 0, 0, 1, 3'd0, 5'd7, 5'd7, 5'd1), 0, 0);
    step(nop, 0, 0);

    // x0 is never forwarded and never stalls
    step(mk(0, 0, 1, 1, 3'd0, 5'd0, 5'd0, 5'd0), 0, 0);
    step(mk(0, 0, 0, 1, 3'd0, 5'd0, 5'd0, 5'd2), 0, 0);
    step(nop, 0, 0);

    // repeated load-use pairs drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 0, 1, 1, 3'd0, 5'd1, 5'd1, 5'd6), 0, 0);
      step(mk(0, 0, 0, 1, 3'd0, 5'd1, 5'd6, 5'd2), 0, 0);
    end

    // reset in the middle of traffic discards everything in flight
    step(mk(0, 0, 0, 1, 3'd3, 5'd1, 5'd1, 5'd4), 0, 0);
    step(mk(0, 0, 0, 1, 3'd3, 5'd4, 5'd4, 5'd5), 0, 1);
    step(nop, 0, 0);

    // randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      r = ctrl_t'({$urandom, $urandom});
      r.rs1 = 5'($urandom_range(0, 3));
      r.rs2 = 5'($urandom_range(0, 3));
      r.rd  = 5'($urandom_range(0, 3));
      r.branch = ($urandom_range(0, 5) == 0);
      r.jump   = ($urandom_range(0, 9) == 0);
      step(r, 1'($urandom), ($urandom_range(0, 60) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Consumes the ID-stage control word produced by the instruction decoder/controller.
- Carries that control word through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates load-use stalls, branch/jump flushes, EX-stage forwarding selects and PCSrcE.
- Sits between the controller and the 5-stage datapath. It is the downstream end of the controller's control-signal interface.

Parameters:
- REG_W, 5, register-address width
- ALUC_W, 3, ALUControl width
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- BranchD, JumpD, MemWriteD, MemReadD, ALUSrcD, RegWriteD  in  1 each  ID-stage decoded controls
- ResultSrcD  in  2  ID-stage result select
- ALUControlD  in  ALUC_W  ID-stage ALU operation
- Rs1D, Rs2D, RdD  in  REG_W each  ID-stage register addresses
- ZeroE  in  1  ALU zero flag, EX stage
- ALUSrcE  out  1  EX control
- ALUControlE  out  ALUC_W  EX control
- MemWriteM, MemReadM  out  1 each  MEM controls
- RegWriteW  out  1  WB control
- ResultSrcW  out  2  WB control
- RdW  out  REG_W  writeback destination
- Rs1E, Rs2E  out  REG_W each  EX source addresses, for the datapath
- PCSrcE  out  1  redirect PC to the branch/jump target
- StallF, StallD  out  1 each  hold the PC and the IF/ID register
- FlushD, FlushE  out  1 each  clear the IF/ID register; clear the ID/EX register
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 regfile, 10 ALUResultM, 01 ResultW
- stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (synchronous, active-high):
  - Clears all E/M/W stage registers, including Rd/Rs fields.
  - Clears both counters.
  - Combinational outputs then evaluate to 0 (ForwardxE = 00).
  - Reset mid-operation discards all in-flight control words in one edge.
- Stage registers:
  - E stage holds BranchE, JumpE, MemWriteE, MemReadE, ALUSrcE, RegWriteE, ResultSrcE, ALUControlE, Rs1E, Rs2E, RdE.
  - M stage holds MemWriteM, MemReadM, RegWriteM, ResultSrcM, RdM.
  - W stage holds RegWriteW, ResultSrcW, RdW.
  - M and W advance every cycle; they are never stalled or flushed.
- PCSrcE = JumpE | (BranchE & ZeroE). Combinational.
- Load-use detection:
  - lwStall = MemReadE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE.
  - A redirect suppresses the stall, because the D instruction is on the wrong path.
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE. On the next edge, FlushE loads all-zero into every E-stage field (a bubble: RegWriteE = MemWriteE = MemReadE = BranchE = JumpE = 0).
- Otherwise the E stage loads the D-stage inputs. The ID/EX register has no stall: a stalled D instruction is re-presented next cycle while a bubble enters E.
- ForwardAE:
  - 10 if RegWriteM & RdM != 0 & RdM == Rs1E;
  - else 01 if RegWriteW & RdW != 0 & RdW == Rs1E;
  - else 00.
  - MEM has priority over WB. ForwardBE is identical using Rs2E.
- Register x0 is never forwarded and never causes a stall.
- Latencies: a control word presented in D appears in E one edge later, in M two edges later, and in W three edges later.
- Counters:
  - stall_cnt increments on each edge where lwStall = 1.
  - flush_cnt increments on each edge where PCSrcE = 1.
  - Both saturate at 2^CNT_W - 1; no wrap.
- All outputs except the stage-register outputs are combinational from current state and inputs; there are no registered hazard outputs.

Test Plan:
- Reset held 2 cycles with nonzero D inputs -> every output 0, counters 0; first valid D word visible on ALUControlE one edge after reset deasserts.
- lw x5 (MemReadD=1, RdD=5), then add with Rs1D=5 -> cycle 2: StallF = StallD = FlushE = 1, stall_cnt = 1; cycle 3: E is a bubble, stall clear; cycle 4: ForwardAE = 01.
- add x3 (RegWriteD=1, RdD=3), then sub with Rs1D=3, Rs2D=3 -> when sub is in E: ForwardAE = ForwardBE = 10. Back-to-back writes to x3 -> 10 chosen over 01.
- beq in E with BranchE=1 and ZeroE=1 -> PCSrcE = FlushD = FlushE = 1, flush_cnt += 1, next E all-zero. With ZeroE=0 -> no flush.
- lw x7 in E, jal (JumpE) alongside a D instruction using x7 in the same cycle → only the jump is in E, so test lwStall with PCSrcE forced via a preceding jump: StallD = 0, FlushE = 1.
- RdD = 0 with RegWriteD = 1 followed by a reader of x0 -> ForwardAE = 00, no stall. With CNT_W = 2, four consecutive stalls -> stall_cnt holds at 3.
